// File: rtl/button_pkg.sv
// Shared types and constants for the button front end: test FSM states,
// input index map and the counter-width helper.
package button_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_PRESS_OUT,
    T_WAIT_REL_IN,
    T_TEST,
    T_PRESS_IN,
    T_WAIT_REL_OUT
  } test_state_t;

  localparam int SLEEP  = 0;
  localparam int AWAKE  = 1;
  localparam int FEED   = 2;
  localparam int PLAY   = 3;
  localparam int TEST   = 4;
  localparam int TILT   = 5;
  localparam int NUM_IN = 6;

  localparam int PULSE_MAX_DEF = 9;

  // Width for a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer. The output
// level follows the synchronized input once it has differed for DEBOUNCE_CYCLES.
module btn_debounce
  import button_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= RST_VAL;
      r_sync  <= RST_VAL;
      r_level <= RST_VAL;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      // Any agreement with the current level restarts the stability window.
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/button_command_gen.sv
// Button/tilt conditioning and command pulse generation for the pet FSM.
// Test-mode protocol is built only when BUTTON_TEST_MODE_EN is defined.
module button_command_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int PULSE_MAX         = PULSE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_n,
  input  logic       btn_awake_n,
  input  logic       btn_feed_n,
  input  logic       btn_play_n,
  input  logic       btn_test_n,
  input  logic       tilt_raw,
  output logic       boton_sleep,
  output logic       boton_awake,
  output logic       boton_feed,
  output logic       boton_play,
  output logic       giro,
  output logic       boton_test,
  output logic [3:0] bpulse_test
);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_deb;
  logic [3:0]        w_press;
  logic [3:0]        r_prev;
  logic [3:0]        r_pulse;
  logic              w_sup;

  assign w_raw = {tilt_raw, btn_test_n, btn_play_n, btn_feed_n, btn_awake_n, btn_sleep_n};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        ((g == TILT) ? 1'b0 : 1'b1)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (w_raw[g]),
      .o_level(w_deb[g])
    );
  end

  assign w_press = ~w_deb[PLAY:SLEEP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_pulse <= '0;
    end else begin
      r_prev  <= w_press;
      r_pulse <= w_press & ~r_prev & {4{~w_sup}};
    end
  end

  assign boton_sleep = r_pulse[SLEEP];
  assign boton_awake = r_pulse[AWAKE];
  assign boton_feed  = r_pulse[FEED];
  assign boton_play  = r_pulse[PLAY];
  assign giro        = w_deb[TILT];

`ifdef BUTTON_TEST_MODE_EN
  localparam int            HW     = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HC_MAX = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [3:0]    PMAX   = 4'(PULSE_MAX);

  test_state_t   r_state, w_state_nx;
  logic [HW-1:0] r_hc, w_hc_nx;
  logic          r_test, w_test_nx;
  logic [3:0]    r_bp, w_bp_nx;
  logic          w_tp;

  assign w_tp = ~w_deb[TEST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= T_IDLE;
      r_hc    <= '0;
      r_test  <= 1'b0;
      r_bp    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hc    <= w_hc_nx;
      r_test  <= w_test_nx;
      r_bp    <= w_bp_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_hc_nx    = r_hc;
    w_test_nx  = r_test;
    w_bp_nx    = r_bp;
    case (r_state)
      T_IDLE: if (w_tp) begin
        w_hc_nx    = '0;
        w_state_nx = T_PRESS_OUT;
      end
      T_PRESS_OUT: begin
        if (!w_tp) begin
          w_state_nx = T_IDLE;
        end else if (r_hc == HC_MAX) begin
          w_test_nx  = 1'b1;
          w_bp_nx    = '0;
          w_state_nx = T_WAIT_REL_IN;
        end else begin
          w_hc_nx = r_hc + HW'(1);
        end
      end
      T_WAIT_REL_IN: if (!w_tp) w_state_nx = T_TEST;
      T_TEST: if (w_tp) begin
        w_hc_nx    = '0;
        w_state_nx = T_PRESS_IN;
      end
      T_PRESS_IN: begin
        // A release before the threshold is a scenario-select press.
        if (!w_tp) begin
          w_bp_nx    = (r_bp == PMAX) ? 4'd1 : r_bp + 4'd1;
          w_state_nx = T_TEST;
        end else if (r_hc == HC_MAX) begin
          w_test_nx  = 1'b0;
          w_state_nx = T_WAIT_REL_OUT;
        end else begin
          w_hc_nx = r_hc + HW'(1);
        end
      end
      T_WAIT_REL_OUT: if (!w_tp) w_state_nx = T_IDLE;
      default: w_state_nx = T_IDLE;
    endcase
  end

  assign w_sup       = r_test;
  assign boton_test  = r_test;
  assign bpulse_test = r_bp;
`else
  logic w_unused_cfg;

  // Test path is not built; the test cell output and its knobs are deliberately dropped.
  assign w_unused_cfg = &{1'b0, w_deb[TEST], (LONG_PRESS_CYCLES > 0), (PULSE_MAX > 0)};
  assign w_sup        = 1'b0;
  assign boton_test   = 1'b0;
  assign bpulse_test  = 4'd0;
`endif

endmodule

// File: tb/tb_button_command_gen.sv
// Directed bench for button_command_gen with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Expectations follow BUTTON_TEST_MODE_EN when it is defined for the build.
module tb_button_command_gen;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int PM = 9;
`ifdef BUTTON_TEST_MODE_EN
  localparam bit TM = 1'b1;
`else
  localparam bit TM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sl_n = 1'b1, aw_n = 1'b1, fd_n = 1'b1, pl_n = 1'b1, ts_n = 1'b1, tilt = 1'b0;
  logic       b_sl, b_aw, b_fd, b_pl, b_giro, b_test;
  logic [3:0] b_bp;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_p[4] = '{default: 0};
  int t_p[4] = '{default: -1};
  int t_rise = -1;
  int t_fall = -1;
  logic prev_test = 1'b0;

  button_command_gen #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .PULSE_MAX        (PM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_sleep_n(sl_n),
    .btn_awake_n(aw_n),
    .btn_feed_n (fd_n),
    .btn_play_n (pl_n),
    .btn_test_n (ts_n),
    .tilt_raw   (tilt),
    .boton_sleep(b_sl),
    .boton_awake(b_aw),
    .boton_feed (b_fd),
    .boton_play (b_pl),
    .giro       (b_giro),
    .boton_test (b_test),
    .bpulse_test(b_bp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/edge recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (b_sl) begin n_p[0]++; t_p[0] = cyc; end
    if (b_aw) begin n_p[1]++; t_p[1] = cyc; end
    if (b_fd) begin n_p[2]++; t_p[2] = cyc; end
    if (b_pl) begin n_p[3]++; t_p[3] = cyc; end
    if (b_test && !prev_test) t_rise = cyc;
    if (!b_test && prev_test) t_fall = cyc;
    prev_test = b_test;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_test(input int hold, input int gap);
    ts_n = 1'b0;
    tick(hold);
    ts_n = 1'b1;
    tick(gap);
  endtask

  initial begin
    int k, s0, s1, s2, s3, r0;

    tick(3);
    chk("rst_sleep", b_sl, 0);
    chk("rst_awake", b_aw, 0);
    chk("rst_feed",  b_fd, 0);
    chk("rst_play",  b_pl, 0);
    chk("rst_giro",  b_giro, 0);
    chk("rst_test",  b_test, 0);
    chk("rst_bp",    b_bp, 0);
    rst = 1'b0;
    tick(2);

    // Tilt: short glitch rejected, stable level follows after 2+4 cycles
    tilt = 1'b1; tick(3); tilt = 1'b0; tick(8);
    chk("tilt_glitch", b_giro, 0);
    tilt = 1'b1; k = cyc;
    tick(5);
    chk("tilt_early", b_giro, 0);
    tick(1);
    chk("tilt_on", b_giro, 1);
    tilt = 1'b0; tick(8);
    chk("tilt_off", b_giro, 0);

    // Simultaneous sleep+awake press -> one pulse each, same cycle
    s0 = n_p[0]; s1 = n_p[1];
    sl_n = 1'b0; aw_n = 1'b0; k = cyc;
    tick(12);
    sl_n = 1'b1; aw_n = 1'b1;
    tick(10);
    chk("sleep_cnt", n_p[0] - s0, 1);
    chk("awake_cnt", n_p[1] - s1, 1);
    chk("sleep_lat", t_p[0] - k, 7);
    chk("awake_lat", t_p[1] - k, 7);

    // Feed with 2-cycle bounces then a 30-cycle hold
    s2 = n_p[2];
    fd_n = 1'b0; tick(2); fd_n = 1'b1; tick(2);
    fd_n = 1'b0; tick(2); fd_n = 1'b1; tick(2);
    fd_n = 1'b0; k = cyc;
    tick(30);
    fd_n = 1'b1;
    tick(12);
    chk("feed_cnt", n_p[2] - s2, 1);
    chk("feed_lat", t_p[2] - k, 7);

    // Long test press -> enter test mode
    ts_n = 1'b0; k = cyc;
    tick(30);
    chk("test_on", b_test, TM);
    chk("bp_entry", b_bp, 0);
`ifdef BUTTON_TEST_MODE_EN
    chk("test_rise_lat", t_rise - k, 27);
`endif
    ts_n = 1'b1;
    tick(10);

    // Play press while in test mode
    s3 = n_p[3];
    pl_n = 1'b0; tick(10); pl_n = 1'b1; tick(12);
    chk("play_supp", n_p[3] - s3, TM ? 0 : 1);

    // Three short presses; first one checks the update cycle
    ts_n = 1'b0; k = cyc;
    tick(8);
    ts_n = 1'b1;
    tick(6);
    chk("bp_before_upd", b_bp, 0);
    tick(1);
    chk("bp_after_upd", b_bp, TM ? 1 : 0);
    tick(1);
    press_test(8, 8);
    press_test(8, 8);
    chk("bp_three", b_bp, TM ? 3 : 0);

    // Long press inside test mode -> exit, scenario retained
    ts_n = 1'b0; k = cyc;
    tick(30);
    chk("test_off", b_test, 0);
    chk("bp_hold", b_bp, TM ? 3 : 0);
`ifdef BUTTON_TEST_MODE_EN
    chk("test_fall_lat", t_fall - k, 27);
`endif
    ts_n = 1'b1;
    tick(10);

    // Re-enter; ten short presses walk 1..9 then wrap to 1
    press_test(30, 10);
    chk("reenter_test", b_test, TM);
    chk("reenter_bp", b_bp, 0);
    for (int i = 0; i < 10; i++) begin
      press_test(8, 8);
      chk($sformatf("bp_seq%0d", i), b_bp, TM ? (i % PM) + 1 : 0);
    end
    press_test(30, 10);
    chk("exit2_test", b_test, 0);
    chk("exit2_bp", b_bp, TM ? 1 : 0);

    // Short press outside test mode does nothing
    press_test(10, 10);
    chk("short_out_test", b_test, 0);
    chk("short_out_bp", b_bp, TM ? 1 : 0);

    // Reset in the middle of a long press
    ts_n = 1'b0;
    tick(10);
    rst = 1'b1;
    #1;
    chk("midrst_test", b_test, 0);
    chk("midrst_bp", b_bp, 0);
    chk("midrst_pulses", {28'd0, b_sl, b_aw, b_fd, b_pl}, 0);
    ts_n = 1'b1;
    tick(3);
    rst = 1'b0;
    s0 = n_p[0] + n_p[1] + n_p[2] + n_p[3];
    r0 = t_rise;
    tick(40);
    chk("post_rst_test", b_test, 0);
    chk("post_rst_bp", b_bp, 0);
    chk("post_rst_pulses", n_p[0] + n_p[1] + n_p[2] + n_p[3] - s0, 0);
    chk("post_rst_entry", t_rise, r0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_command_gen.md
# button_command_gen

Input-conditioning front end for the pet control FSM. Synchronizes and debounces the raw push-buttons and the tilt switch, then issues one-cycle command pulses (sleep, awake, feed, play). It also runs the test-mode protocol: a long press enters test mode, short presses select a scenario number, and a second long press exits. It drives the FSM command inputs `boton_sleep`, `boton_awake`, `boton_feed`, `boton_play`, `giro`, `boton_test` and `bpulse_test[3:0]`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles before a debounced level changes (5 ms at 50 MHz).
- `LONG_PRESS_CYCLES`, default 250000000: held-press cycles that qualify as a long press (5 s).
- `PULSE_MAX`, default 9: highest test scenario number.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_sleep_n`, `btn_awake_n`, `btn_feed_n`, `btn_play_n`, `btn_test_n`, in, 1 each: raw buttons, active-low, asynchronous.
- `tilt_raw`, in, 1: raw tilt switch, active-high, asynchronous.
- `boton_sleep`, `boton_awake`, `boton_feed`, `boton_play`, out, 1 each: one-cycle press pulses.
- `giro`, out, 1: debounced tilt level.
- `boton_test`, out, 1: high while test mode is active.
- `bpulse_test`, out, 4: selected test scenario, 0 to `PULSE_MAX`.

## Operation
- **Input path.** Every raw input passes through a 2-flop synchronizer, then a debounce cell.
  - The debounced level takes the synchronized value after that value has differed from the current level for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any return to the current level before then clears the counter.
- **Command pulses.** A command pulse asserts for exactly 1 cycle on each rising edge of a debounced, inverted button level.
  - Holding a button produces one pulse only.
  - Command pulses are suppressed while `boton_test`=1.
- **Tilt.** `giro` is the debounced tilt level. It is never suppressed.
- **Test FSM.** Input is the debounced test-button level (`tp` = pressed). A hold counter `hc` is used for long-press timing.
  - T_IDLE: on `tp`, clear `hc` and go to T_PRESS_OUT.
  - T_PRESS_OUT: on release, go to T_IDLE; a short press outside test mode has no effect. When `hc`==`LONG_PRESS_CYCLES`-1, set `boton_test`=1, set `bpulse_test`=0 and go to T_WAIT_REL_IN. Otherwise increment `hc`.
  - T_WAIT_REL_IN: on release, go to T_TEST.
  - T_TEST: on `tp`, clear `hc` and go to T_PRESS_IN.
  - T_PRESS_IN: on release, update `bpulse_test` (PULSE_MAX wraps to 1, otherwise +1) and go to T_TEST. When `hc` reaches `LONG_PRESS_CYCLES`-1, set `boton_test`=0 and go to T_WAIT_REL_OUT. That long press leaves `bpulse_test` unchanged.
  - T_WAIT_REL_OUT: on release, go to T_IDLE.
- `bpulse_test` holds its value after exit, so the FSM samples it on the cycle `boton_test` falls. It is cleared only on the next test entry or on reset.
- Presses of other buttons have no effect on the test FSM.
- Simultaneous rising edges on several command buttons each produce their own pulse in the same cycle.

## Timing
- Reset values: all outputs 0, test FSM in T_IDLE, debounced levels "released" (tilt 0), all counters 0.
- Reset mid-operation, including mid-long-press or mid-test, returns immediately to that state. Releasing a held button afterwards produces no pulse.
- Latency from raw edge to pulse: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- `boton_test` rises or falls `LONG_PRESS_CYCLES` cycles after the debounced press is seen.
- `bpulse_test` updates 1 cycle after the debounced release.
- All outputs are registered.
- Counter widths are `$clog2(param)`. Counters never wrap; `hc` stops at the threshold.

## Configuration
- `BUTTON_TEST_MODE_EN` defined: test FSM present, behaving as described above.
- `BUTTON_TEST_MODE_EN` undefined:
  - test FSM and hold counter are omitted;
  - `boton_test` and `bpulse_test` are tied to 0;
  - `btn_test_n` is ignored;
  - command pulses are never suppressed.

## Structure
- Package `button_pkg` holds:
  - test FSM state enum (T_IDLE, T_PRESS_OUT, T_WAIT_REL_IN, T_TEST, T_PRESS_IN, T_WAIT_REL_OUT);
  - button index constants SLEEP=0, AWAKE=1, FEED=2, PLAY=3, TEST=4, TILT=5;
  - `PULSE_MAX` default.
- Sub-module `btn_debounce` (synchronizer plus stable counter, parameter `DEBOUNCE_CYCLES`), instantiated 6 times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Drive `btn_feed_n` low with 2-cycle bounces, then hold 30 cycles -> exactly one `boton_feed` pulse, 7 cycles after the last bounce.
- Hold `btn_test_n` 30 cycles -> `boton_test` rises 20 cycles after the debounced press, `bpulse_test`=0. Press `btn_play_n` while in test mode -> no `boton_play` pulse.
- In test mode, give 3 short presses (8 cycles each) -> `bpulse_test`=3. Then a long press -> `boton_test` falls, `bpulse_test` stays 3.
- In test mode, give 10 short presses -> `bpulse_test` sequence 1..9 then 1.
- Short test press (10 cycles) outside test mode -> `boton_test` stays 0, `bpulse_test` unchanged.
- Assert `rst` at cycle 10 of a long press -> all outputs 0. Releasing afterwards gives no pulse and no test entry.
